// File: rtl/sum_serial_ctrl.sv
// Bit-serial adder sequencer: drives one shared full-adder cell LSB-first over WIDTH cycles.
// Accept-to-done latency WIDTH+1 cycles; start is only honoured in IDLE (no queueing).
module sum_serial_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             add_x,
    output logic             add_y,
    output logic             add_c,
    input  logic             add_s,
    input  logic             add_co,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_sh_q;
    logic [WIDTH-1:0] b_sh_q;
    logic [WIDTH-1:0] sum_q;
    logic [WIDTH-1:0] sum_d;
    logic [CW-1:0]    cnt_q;
    logic             carry_q;
    logic             cout_q;
    logic             done_q;
    logic             busy_q;
    logic             run;

    assign run = (state_q == RUN);

    // Adder inputs are forced low outside RUN so the shared cell sees no activity.
    assign add_x = run & a_sh_q[0];
    assign add_y = run & b_sh_q[0];
    assign add_c = run & carry_q;

    always_comb begin
        sum_d            = sum_q >> 1;
        sum_d[WIDTH-1]   = add_s;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        a_sh_q  <= a;
                        b_sh_q  <= b;
                        carry_q <= cin;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    sum_q   <= sum_d;
                    a_sh_q  <= a_sh_q >> 1;
                    b_sh_q  <= b_sh_q >> 1;
                    carry_q <= add_co;
                    cnt_q   <= cnt_q + CW'(1);
                    if (cnt_q == LAST) begin
                        cout_q  <= add_co;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_sum_serial_ctrl.sv
// Scoreboard bench for sum_serial_ctrl: WIDTH=4 and WIDTH=1 instances, each with its own full-adder cell.
module tb_sum_serial_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       start, cin, add_x, add_y, add_c, add_s, add_co, busy, done, cout;
    logic [3:0] a, b, sum;
    logic       start1, cin1, add_x1, add_y1, add_c1, add_s1, add_co1, busy1, done1, cout1;
    logic [0:0] a1, b1, sum1;

    assign add_s   = add_x ^ add_y ^ add_c;
    assign add_co  = (add_x & add_y) | (add_c & (add_x ^ add_y));
    assign add_s1  = add_x1 ^ add_y1 ^ add_c1;
    assign add_co1 = (add_x1 & add_y1) | (add_c1 & (add_x1 ^ add_y1));

    sum_serial_ctrl #(.WIDTH(4)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
        .add_x(add_x), .add_y(add_y), .add_c(add_c), .add_s(add_s), .add_co(add_co),
        .busy(busy), .done(done), .sum(sum), .cout(cout)
    );

    sum_serial_ctrl #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .cin(cin1),
        .add_x(add_x1), .add_y(add_y1), .add_c(add_c1), .add_s(add_s1), .add_co(add_co1),
        .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
    );

    int         checks = 0;
    int         failures = 0;
    int         starts = 0;
    int         dones = 0;
    int         starts1 = 0;
    int         dones1 = 0;
    logic [4:0] exp_q[$];
    logic [1:0] exp1_q[$];
    logic [4:0] e_mon;
    logic [1:0] e1_mon;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: every done pulse pops the oldest expected result.
    always @(negedge clk) begin
        if (!rst && done) begin
            dones++;
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done actual=%0h required=none", {cout, sum});
            end else begin
                e_mon = exp_q.pop_front();
                check("result_w4", 32'({cout, sum}), 32'(e_mon));
            end
        end
        if (!rst && done1) begin
            dones1++;
            if (exp1_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done_w1 actual=%0h required=none", {cout1, sum1});
            end else begin
                e1_mon = exp1_q.pop_front();
                check("result_w1", 32'({cout1, sum1}), 32'(e1_mon));
            end
        end
    end

    task automatic issue(input logic [3:0] aa, input logic [3:0] bb, input logic ci);
        a = aa;
        b = bb;
        cin = ci;
        start = 1'b1;
        exp_q.push_back({1'b0, aa} + {1'b0, bb} + {4'b0, ci});
        starts++;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < 20);
        check("done_seen", 32'(done), 1);
    endtask

    task automatic run_add(input logic [3:0] aa, input logic [3:0] bb, input logic ci);
        int n;
        @(negedge clk);
        issue(aa, bb, ci);
        wait_done(n);
        @(negedge clk);
    endtask

    task automatic run_add1(input logic aa, input logic bb, input logic ci, input logic [1:0] expv);
        int n;
        @(negedge clk);
        a1 = aa;
        b1 = bb;
        cin1 = ci;
        start1 = 1'b1;
        exp1_q.push_back(expv);
        starts1++;
        @(posedge clk);
        #1 start1 = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done1 && n < 10);
        check("w1_latency", 32'(n), 2);
        @(negedge clk);
    endtask

    int          n;
    int          busy_cnt;
    logic [17:0] got;
    logic [17:0] got_exp;

    initial begin
        rst = 1'b1;
        start = 0; a = 0; b = 0; cin = 0;
        start1 = 0; a1 = 0; b1 = 0; cin1 = 0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_sum_cout", 32'({cout, sum}), 0);
        check("rst_adder_drive", 32'({add_x, add_y, add_c}), 0);
        check("rst_w1", 32'({busy1, done1, cout1, sum1}), 0);
        @(negedge clk);
        rst = 1'b0;

        // 5 + 3: latency, busy width, adder drive on the first RUN cycle.
        @(negedge clk);
        issue(4'd5, 4'd3, 1'b0);
        n = 0;
        busy_cnt = 0;
        while (n < 20) begin
            @(negedge clk);
            n++;
            if (busy) busy_cnt++;
            if (n == 1) check("first_drive", 32'({add_x, add_y, add_c}), 32'h6);
            if (done) break;
        end
        check("latency", 32'(n), 5);
        @(negedge clk);
        if (busy) busy_cnt++;
        check("busy_cycles", 32'(busy_cnt), 5);
        check("idle_drive", 32'({add_x, add_y, add_c}), 0);

        run_add(4'd15, 4'd1, 1'b0);
        run_add(4'd7, 4'd8, 1'b1);
        run_add(4'd0, 4'd0, 1'b1);

        for (int ai = 0; ai < 16; ai++)
            for (int bi = 0; bi < 16; bi++)
                for (int ci = 0; ci < 2; ci++)
                    run_add(4'(ai), 4'(bi), 1'(ci));

        // Second request two cycles into 9 + 4 must be dropped.
        @(negedge clk);
        issue(4'd9, 4'd4, 1'b0);
        repeat (2) @(negedge clk);
        a = 4'd2;
        b = 4'd2;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(n);
        repeat (8) @(negedge clk);

        // Reset two cycles into 11 + 7 aborts with no done.
        @(negedge clk);
        a = 4'd11; b = 4'd7; cin = 1'b0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (2) @(negedge clk);
        check("pre_rst_carry", 32'(add_c), 1);
        rst = 1'b1;
        #1;
        check("abort_busy_done", 32'({busy, done}), 0);
        check("abort_sum_cout", 32'({cout, sum}), 0);
        check("abort_drive", 32'({add_x, add_y, add_c}), 0);
        start = 1'b1;
        repeat (2) @(posedge clk);
        #1 check("start_in_rst", 32'(busy), 0);
        @(negedge clk);
        start = 1'b0;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("idle_after_rst", 32'({busy, done}), 0);
        run_add(4'd6, 4'd6, 1'b0);

        // start held high: three back-to-back adds, a changed between accepts.
        @(negedge clk);
        a = 4'd1; b = 4'd2; cin = 1'b0; start = 1'b1;
        exp_q.push_back(5'd3);
        exp_q.push_back(5'd5);
        exp_q.push_back(5'd12);
        starts += 3;
        got = '0;
        got_exp = 18'h10410;
        @(posedge clk);
        for (int k = 1; k <= 18; k++) begin
            @(negedge clk);
            got[k-1] = done;
            if (k == 1) a = 4'd3;
            if (k == 7) a = 4'd10;
            if (k == 13) start = 1'b0;
        end
        check("b2b_done_pattern", 32'(got), 32'(got_exp));
        repeat (3) @(negedge clk);

        run_add1(1'b1, 1'b1, 1'b1, 2'b11);
        run_add1(1'b0, 1'b1, 1'b0, 2'b01);
        run_add1(1'b1, 1'b1, 1'b0, 2'b10);

        repeat (4) @(negedge clk);
        check("done_count", 32'(dones), 32'(starts));
        check("queue_drained", 32'(exp_q.size()), 0);
        check("done_count_w1", 32'(dones1), 32'(starts1));
        check("queue_drained_w1", 32'(exp1_q.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

endmodule
